// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial WIDTH-bit adder; one shared full-adder cell processes one bit per clock, LSB first.
// Latency : start accepted at edge E0, result and done visible in the cycle after edge E(WIDTH).
// Backpr. : start is accepted only in IDLE or DONE; start while busy is ignored.
// Ports   : clk, rst (sync, active-high), start, a/b operands in; busy, done pulse, sum/cout registered result out.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, rs;
    logic             c;
    logic [CW-1:0]    cnt;

    // Full-adder cell built from two half adders and an OR of their carries.
    logic s1, c1, c2, bit_s, cy;

    half_adder u_ha0 (.x(ra[0]), .y(rb[0]), .s(s1),    .co(c1));
    half_adder u_ha1 (.x(s1),    .y(c),     .s(bit_s), .co(c2));
    assign cy = c1 | c2;

    logic accept;
    logic last;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a start seen in DONE launches the next add immediately.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ra  <= a;
                rb  <= b;
                c   <= 1'b0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                ra  <= ra >> 1;
                rb  <= rb >> 1;
                rs  <= {bit_s, rs[WIDTH-1:1]};
                c   <= cy;
                cnt <= cnt + 1'b1;
                // The final bit is still in flight, so take it from the cell rather than rs.
                if (last) begin
                    sum  <= {bit_s, rs[WIDTH-1:1]};
                    cout <= cy;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        st8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        busy8, done8, cout8;

    logic        st32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, sum32;
    logic        busy32, done32, cout32;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(st32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one 8-bit add and wait for done. edges counts edges from the cycle
    // start is presented to the cycle done is visible. Operands are scrambled
    // every cycle after the accepting edge.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        output int edges, output int bcyc);
        a8 = x; b8 = y; st8 = 1'b1;
        step();
        st8 = 1'b0;
        edges = 1;
        bcyc  = 0;
        while (!done8 && edges < 50) begin
            if (busy8) bcyc++;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            step();
            edges++;
        end
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y, output int edges);
        a32 = x; b32 = y; st32 = 1'b1;
        step();
        st32 = 1'b0;
        edges = 1;
        while (!done32 && edges < 100) begin
            a32 = $urandom;
            b32 = $urandom;
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_err++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, want all zero", busy8, done8, sum8, cout8);
        end
        n_cmp++;
        if ({busy32, done32, sum32, cout32} !== 35'd0) begin
            n_err++;
            $display("FAIL reset32: busy=%b done=%b sum=%h cout=%b, want all zero", busy32, done32, sum32, cout32);
        end
        step();
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        int edges, bcyc;
        run8(8'h5A, 8'hA5, edges, bcyc);
        n_cmp++;
        if (bcyc !== 8) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bcyc);
        end
        n_cmp++;
        if ({done8, busy8} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_done_cycle: done=%b busy=%b, want done=1 busy=0", done8, busy8);
        end
        n_cmp++;
        if ({cout8, sum8} !== 9'h0FF) begin
            n_err++;
            $display("FAIL basic_result: got %h, want 0ff", {cout8, sum8});
        end
        step();
        n_cmp++;
        if (done8 !== 1'b0 || {cout8, sum8} !== 9'h0FF) begin
            n_err++;
            $display("FAIL basic_pulse_hold: done=%b result=%h, want done=0 result=0ff", done8, {cout8, sum8});
        end
    endtask

    task automatic test_carry();
        int edges, bcyc;
        run8(8'hFF, 8'h01, edges, bcyc);
        n_cmp++;
        if (edges !== 9) begin
            n_err++;
            $display("FAIL carry_latency: got %0d edges, want 9", edges);
        end
        n_cmp++;
        if ({cout8, sum8} !== 9'h100) begin
            n_err++;
            $display("FAIL carry_result: got %h, want 100", {cout8, sum8});
        end
        step(); step();
        n_cmp++;
        if ({cout8, sum8} !== 9'h100 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL carry_hold: result=%h done=%b, want 100 and done=0", {cout8, sum8}, done8);
        end
    endtask

    task automatic test_start_with_reset();
        rst = 1'b1; st8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        step();
        rst = 1'b0; st8 = 1'b0;
        n_cmp++;
        if (busy8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
            n_err++;
            $display("FAIL start_rst_same_edge: busy=%b result=%h, want busy=0 result=000", busy8, {cout8, sum8});
        end
        step();
        n_cmp++;
        if (busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL start_rst_dropped: busy=%b, want 0", busy8);
        end
    endtask

    task automatic test_back_to_back();
        int guard, gap;
        a8 = 8'h80; b8 = 8'h80; st8 = 1'b1;
        step();                       // accepted; busy cycle 1
        st8 = 1'b0;
        step();                       // busy cycle 2
        step();                       // busy cycle 3
        a8 = 8'h01; b8 = 8'h01; st8 = 1'b1;
        step();
        st8 = 1'b0;
        guard = 0;
        while (!done8 && guard < 40) begin
            step();
            guard++;
        end
        n_cmp++;
        if ({cout8, sum8} !== 9'h100 || done8 !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_start: done=%b result=%h, want done=1 result=100", done8, {cout8, sum8});
        end
        // Start held high through the DONE cycle.
        a8 = 8'h0F; b8 = 8'h01; st8 = 1'b1;
        step();
        st8 = 1'b0;
        a8 = 8'hEE; b8 = 8'hEE;
        gap = 1;
        while (!done8 && gap < 40) begin
            step();
            gap++;
        end
        n_cmp++;
        if (gap !== 9) begin
            n_err++;
            $display("FAIL b2b_period: got %0d cycles between dones, want 9", gap);
        end
        n_cmp++;
        if ({cout8, sum8} !== 9'h010 || busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_result: result=%h busy=%b, want 010 and busy=0", {cout8, sum8}, busy8);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        a8 = 8'h3C; b8 = 8'h0F; st8 = 1'b1;
        step();                       // busy cycle 1
        st8 = 1'b0;
        step(); step(); step();       // busy cycle 4
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, want all zero", busy8, done8, sum8, cout8);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 || busy8) seen++;
            step();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: %0d cycles with done or busy, want 0", seen);
        end
    endtask

    task automatic test_capture_isolation();
        int edges, bcyc;
        logic [8:0] exp;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            exp = {1'b0, x} + {1'b0, y};
            run8(x, y, edges, bcyc);
            n_cmp++;
            if (done8 !== 1'b1 || {cout8, sum8} !== exp) begin
                n_err++;
                $display("FAIL isolation %h+%h: done=%b result=%h, want %h", x, y, done8, {cout8, sum8}, exp);
            end
        end
    endtask

    task automatic test_random8();
        int edges, bcyc;
        logic [8:0] exp;
        for (int k = 0; k < 1000; k++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            exp = {1'b0, x} + {1'b0, y};
            run8(x, y, edges, bcyc);
            n_cmp++;
            if (done8 !== 1'b1 || edges !== 9 || {cout8, sum8} !== exp) begin
                n_err++;
                $display("FAIL random8 %h+%h: done=%b edges=%0d result=%h, want done=1 edges=9 %h",
                         x, y, done8, edges, {cout8, sum8}, exp);
            end
        end
    endtask

    task automatic test_random32();
        int edges;
        logic [32:0] exp;
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if (k == 0) begin x = 32'hFFFF_FFFF; y = 32'h1; end
            exp = {1'b0, x} + {1'b0, y};
            run32(x, y, edges);
            n_cmp++;
            if (done32 !== 1'b1 || edges !== 33 || {cout32, sum32} !== exp) begin
                n_err++;
                $display("FAIL random32 %h+%h: done=%b edges=%0d result=%h, want done=1 edges=33 %h",
                         x, y, done32, edges, {cout32, sum32}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_with_reset();
        test_back_to_back();
        test_reset_mid();
        test_capture_isolation();
        test_random8();
        test_random32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
